// File: rtl/fabric_edge_port_if.sv
// Shared tile-link types and the host/tile signal bundle of fabric_edge_port.
// The slave modport is the port's own view; master is the harness/host view.
package fabric_edge_port_pkg;
  typedef logic [7:0] t_tile_id;
  typedef logic [4:0] t_fab_ready;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
    logic        write;
  } t_tile_trans;
endpackage

interface fabric_edge_port_if;
  import fabric_edge_port_pkg::*;

  logic        host_req_valid;
  t_tile_trans host_req;
  logic        host_req_ready;
  logic        out_req_valid;
  t_tile_trans out_req;
  t_fab_ready  in_ready;
  logic        in_req_valid;
  t_tile_trans in_req;
  t_fab_ready  out_ready;
  logic        host_rsp_valid;
  t_tile_trans host_rsp;
  logic        host_rsp_ready;
  logic        rx_overflow;
  logic [15:0] tx_count;
  logic [15:0] rx_count;

  modport slave (
    input  host_req_valid, host_req, in_ready, in_req_valid, in_req, host_rsp_ready,
    output host_req_ready, out_req_valid, out_req, out_ready, host_rsp_valid, host_rsp,
           rx_overflow, tx_count, rx_count
  );

  modport master (
    output host_req_valid, host_req, in_ready, in_req_valid, in_req, host_rsp_ready,
    input  host_req_ready, out_req_valid, out_req, out_ready, host_rsp_valid, host_rsp,
           rx_overflow, tx_count, rx_count
  );
endinterface

// File: rtl/fabric_edge_port.sv
// Mesh edge endpoint: TX FIFO routed dimension-order into the attached tile, RX FIFO toward the host.
// Define EDGE_PORT_STATS_EN to build the saturating tx_count/rx_count statistics.
module fabric_edge_port
  import fabric_edge_port_pkg::*;
#(
  parameter int ATTACH_COL = 1,
  parameter int ATTACH_ROW = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  fabric_edge_port_if.slave port_if
);

  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [AW:0] ptr_t;

  localparam logic [3:0] ACOL        = 4'(ATTACH_COL);
  localparam logic [3:0] AROW        = 4'(ATTACH_ROW);
  localparam ptr_t       RDY_MAX_OCC = ptr_t'(FIFO_DEPTH - 2);

  function automatic logic [2:0] route_dir(input t_tile_id tgt);
    if (tgt[7:4] > ACOL)      return 3'd1;
    else if (tgt[7:4] < ACOL) return 3'd3;
    else if (tgt[3:0] > AROW) return 3'd2;
    else if (tgt[3:0] < AROW) return 3'd0;
    else                      return 3'd4;
  endfunction

  function automatic logic is_full(input ptr_t wr, input ptr_t rd);
    return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  endfunction

  // TX FIFO: host push, pop when the routed direction's ready bit is high
  t_tile_trans tx_mem_q [FIFO_DEPTH];
  ptr_t        tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic        tx_empty, tx_full, tx_push, tx_pop;
  logic [2:0]  tx_dir;
  t_tile_trans tx_head;

  always_comb begin
    tx_empty = (tx_wr_q == tx_rd_q);
    tx_full  = is_full(tx_wr_q, tx_rd_q);
    tx_head  = tx_mem_q[tx_rd_q[AW-1:0]];
    tx_dir   = route_dir(tx_head.address[31:24]);
    tx_push  = port_if.host_req_valid && !tx_full;
    tx_pop   = !tx_empty && port_if.in_ready[tx_dir];
    tx_wr_d  = tx_wr_q + ptr_t'(tx_push);
    tx_rd_d  = tx_rd_q + ptr_t'(tx_pop);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= port_if.host_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
    end
  end

  assign port_if.host_req_ready = !tx_full;
  assign port_if.out_req_valid  = !tx_empty;
  // Head is masked so the link sees zeros while idle, without resetting storage
  assign port_if.out_req        = tx_empty ? '0 : tx_head;

  // RX FIFO: tile valids cannot stall, so a full FIFO drops and flags overflow
  t_tile_trans rx_mem_q [FIFO_DEPTH];
  ptr_t        rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d, rx_occ_d;
  logic        rx_empty, rx_full, rx_push, rx_pop, rx_drop;
  t_fab_ready  out_ready_q, out_ready_d;
  logic        rx_ovf_q, rx_ovf_d;

  always_comb begin
    rx_empty    = (rx_wr_q == rx_rd_q);
    rx_full     = is_full(rx_wr_q, rx_rd_q);
    rx_push     = port_if.in_req_valid && !rx_full;
    rx_drop     = port_if.in_req_valid && rx_full;
    rx_pop      = !rx_empty && port_if.host_rsp_ready;
    rx_wr_d     = rx_wr_q + ptr_t'(rx_push);
    rx_rd_d     = rx_rd_q + ptr_t'(rx_pop);
    rx_occ_d    = rx_wr_d - rx_rd_d;
    out_ready_d = (rx_occ_d <= RDY_MAX_OCC) ? '1 : '0;
    rx_ovf_d    = rx_ovf_q | rx_drop;
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_q[AW-1:0]] <= port_if.in_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      out_ready_q <= '1;
      rx_ovf_q    <= 1'b0;
    end else begin
      rx_wr_q     <= rx_wr_d;
      rx_rd_q     <= rx_rd_d;
      out_ready_q <= out_ready_d;
      rx_ovf_q    <= rx_ovf_d;
    end
  end

  assign port_if.out_ready      = out_ready_q;
  assign port_if.host_rsp_valid = !rx_empty;
  assign port_if.host_rsp       = rx_empty ? '0 : rx_mem_q[rx_rd_q[AW-1:0]];
  assign port_if.rx_overflow    = rx_ovf_q;

`ifdef EDGE_PORT_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  always_comb begin
    tx_cnt_d = tx_pop  ? sat_inc(tx_cnt_q) : tx_cnt_q;
    rx_cnt_d = rx_push ? sat_inc(rx_cnt_q) : rx_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  assign port_if.tx_count = tx_cnt_q;
  assign port_if.rx_count = rx_cnt_q;
`else
  assign port_if.tx_count = '0;
  assign port_if.rx_count = '0;
`endif

endmodule

// File: tb/tb_fabric_edge_port.sv
// Directed bench for fabric_edge_port: vector table for routing/RX flow, hand sequences for stall and reset.
module tb_fabric_edge_port;
  import fabric_edge_port_pkg::*;

`ifdef EDGE_PORT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fabric_edge_port_if bus ();

  fabric_edge_port #(
    .ATTACH_COL(1),
    .ATTACH_ROW(1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .port_if(bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        hv;
    t_tile_trans hreq;
    logic [4:0]  rdy;
    logic        iv;
    t_tile_trans ireq;
    logic        hrr;
    logic        e_hrr;
    logic        e_orv;
    t_tile_trans e_oreq;
    logic [4:0]  e_ordy;
    logic        e_hrv;
    t_tile_trans e_hrsp;
    logic        e_ovf;
  } vec_t;

  vec_t vt [20];

  function automatic t_tile_trans mk(input logic [7:0] tgt, input logic [7:0] tag);
    t_tile_trans t;
    t.address = {tgt, 16'h0, tag};
    t.data    = {24'hDA7A00, tag};
    t.write   = tag[0];
    return t;
  endfunction

  function automatic vec_t v(input logic hv, input t_tile_trans hreq, input logic [4:0] rdy,
                             input logic iv, input t_tile_trans ireq, input logic hrr,
                             input logic e_hrr, input logic e_orv, input t_tile_trans e_oreq,
                             input logic [4:0] e_ordy, input logic e_hrv,
                             input t_tile_trans e_hrsp, input logic e_ovf);
    vec_t r;
    r.hv = hv; r.hreq = hreq; r.rdy = rdy; r.iv = iv; r.ireq = ireq; r.hrr = hrr;
    r.e_hrr = e_hrr; r.e_orv = e_orv; r.e_oreq = e_oreq; r.e_ordy = e_ordy;
    r.e_hrv = e_hrv; r.e_hrsp = e_hrsp; r.e_ovf = e_ovf;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_t(input string name, input t_tile_trans act, input t_tile_trans exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_hrr"},  16'(bus.host_req_ready), 16'd1);
    chk({tag, "_orv"},  16'(bus.out_req_valid), 16'd0);
    chk_t({tag, "_oreq"}, bus.out_req, '0);
    chk({tag, "_ordy"}, 16'(bus.out_ready), 16'h1F);
    chk({tag, "_hrv"},  16'(bus.host_rsp_valid), 16'd0);
    chk_t({tag, "_hrsp"}, bus.host_rsp, '0);
    chk({tag, "_ovf"},  16'(bus.rx_overflow), 16'd0);
    chk({tag, "_txc"},  bus.tx_count, 16'd0);
    chk({tag, "_rxc"},  bus.rx_count, 16'd0);
  endtask

  initial begin
    t_tile_trans z, ta, tb_, tc, td;
    t_tile_trans r [6];
    t_tile_trans e [5];
    t_tile_trans f [3];

    z   = '0;
    ta  = mk(8'h31, 8'h01);
    tb_ = mk(8'h11, 8'h02);
    tc  = mk(8'h01, 8'h03);
    td  = mk(8'h10, 8'h04);
    for (int i = 0; i < 6; i++) r[i] = mk(8'h55, 8'(8'h20 + i));
    for (int i = 0; i < 5; i++) e[i] = mk(8'h13, 8'(8'h40 + i));
    for (int i = 0; i < 3; i++) f[i] = mk(8'h12, 8'(8'h60 + i));

    //            hv  hreq rdy       iv  ireq  hrr  hrr orv oreq ordy    hrv hrsp ovf
    vt[0]  = v(1, ta,  5'b00010, 0, z,    0,   1, 1, ta,  5'h1F, 0, z,    0);
    vt[1]  = v(0, z,   5'b00010, 0, z,    0,   1, 0, z,   5'h1F, 0, z,    0);
    vt[2]  = v(1, tb_, 5'b00010, 0, z,    0,   1, 1, tb_, 5'h1F, 0, z,    0);
    vt[3]  = v(0, z,   5'b00010, 0, z,    0,   1, 1, tb_, 5'h1F, 0, z,    0);
    vt[4]  = v(0, z,   5'b10000, 0, z,    0,   1, 0, z,   5'h1F, 0, z,    0);
    vt[5]  = v(1, tc,  5'b00001, 0, z,    0,   1, 1, tc,  5'h1F, 0, z,    0);
    vt[6]  = v(0, z,   5'b00001, 0, z,    0,   1, 1, tc,  5'h1F, 0, z,    0);
    vt[7]  = v(0, z,   5'b01000, 0, z,    0,   1, 0, z,   5'h1F, 0, z,    0);
    vt[8]  = v(1, td,  5'b00100, 0, z,    0,   1, 1, td,  5'h1F, 0, z,    0);
    vt[9]  = v(0, z,   5'b00001, 0, z,    0,   1, 0, z,   5'h1F, 0, z,    0);
    vt[10] = v(0, z,   5'b00000, 1, r[0], 0,   1, 0, z,   5'h1F, 1, r[0], 0);
    vt[11] = v(0, z,   5'b00000, 1, r[1], 0,   1, 0, z,   5'h1F, 1, r[0], 0);
    vt[12] = v(0, z,   5'b00000, 1, r[2], 0,   1, 0, z,   5'h00, 1, r[0], 0);
    vt[13] = v(0, z,   5'b00000, 1, r[3], 0,   1, 0, z,   5'h00, 1, r[0], 0);
    vt[14] = v(0, z,   5'b00000, 1, r[4], 0,   1, 0, z,   5'h00, 1, r[0], 1);
    vt[15] = v(0, z,   5'b00000, 0, z,    1,   1, 0, z,   5'h00, 1, r[1], 1);
    vt[16] = v(0, z,   5'b00000, 0, z,    1,   1, 0, z,   5'h1F, 1, r[2], 1);
    vt[17] = v(0, z,   5'b00000, 1, r[5], 1,   1, 0, z,   5'h1F, 1, r[3], 1);
    vt[18] = v(0, z,   5'b00000, 0, z,    1,   1, 0, z,   5'h1F, 1, r[5], 1);
    vt[19] = v(0, z,   5'b00000, 0, z,    1,   1, 0, z,   5'h1F, 0, z,    1);

    bus.host_req_valid = 1'b0;
    bus.host_req       = '0;
    bus.in_ready       = '0;
    bus.in_req_valid   = 1'b0;
    bus.in_req         = '0;
    bus.host_rsp_ready = 1'b0;

    #2 rst = 1'b1;
    #2 chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      bus.host_req_valid = vt[i].hv;
      bus.host_req       = vt[i].hreq;
      bus.in_ready       = vt[i].rdy;
      bus.in_req_valid   = vt[i].iv;
      bus.in_req         = vt[i].ireq;
      bus.host_rsp_ready = vt[i].hrr;
      step();
      chk($sformatf("v%0d_hrr", i),  16'(bus.host_req_ready), 16'(vt[i].e_hrr));
      chk($sformatf("v%0d_orv", i),  16'(bus.out_req_valid), 16'(vt[i].e_orv));
      chk_t($sformatf("v%0d_oreq", i), bus.out_req, vt[i].e_oreq);
      chk($sformatf("v%0d_ordy", i), 16'(bus.out_ready), 16'(vt[i].e_ordy));
      chk($sformatf("v%0d_hrv", i),  16'(bus.host_rsp_valid), 16'(vt[i].e_hrv));
      chk_t($sformatf("v%0d_hrsp", i), bus.host_rsp, vt[i].e_hrsp);
      chk($sformatf("v%0d_ovf", i),  16'(bus.rx_overflow), 16'(vt[i].e_ovf));
    end
    chk("table_txc", bus.tx_count, STATS ? 16'd4 : 16'd0);
    chk("table_rxc", bus.rx_count, STATS ? 16'd5 : 16'd0);

    // South-bound burst held off by in_ready[2] = 0 for five cycles
    bus.in_ready       = '0;
    bus.in_req_valid   = 1'b0;
    bus.host_rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.host_req_valid = 1'b1;
      bus.host_req       = e[k];
      step();
      chk_t($sformatf("bp_hold%0d_oreq", k), bus.out_req, e[0]);
      chk($sformatf("bp_hold%0d_orv", k), 16'(bus.out_req_valid), 16'd1);
      chk($sformatf("bp_hold%0d_hrr", k), 16'(bus.host_req_ready), (k >= 3) ? 16'd0 : 16'd1);
    end
    bus.in_ready = 5'b00100;
    step();
    chk_t("bp_rel0_oreq", bus.out_req, e[1]);
    chk("bp_rel0_hrr", 16'(bus.host_req_ready), 16'd1);
    bus.host_req_valid = 1'b0;
    for (int k = 2; k < 4; k++) begin
      step();
      chk_t($sformatf("bp_rel%0d_oreq", k - 1), bus.out_req, e[k]);
      chk($sformatf("bp_rel%0d_orv", k - 1), 16'(bus.out_req_valid), 16'd1);
    end
    step();
    chk("bp_done_orv", 16'(bus.out_req_valid), 16'd0);
    chk("bp_done_hrr", 16'(bus.host_req_ready), 16'd1);
    chk("bp_txc", bus.tx_count, STATS ? 16'd8 : 16'd0);

    // Three stalled TX entries, then reset lands between clock edges
    bus.in_ready = '0;
    for (int k = 0; k < 3; k++) begin
      bus.host_req_valid = 1'b1;
      bus.host_req       = f[k];
      step();
    end
    bus.host_req_valid = 1'b0;
    chk("pre_rst_orv", 16'(bus.out_req_valid), 16'd1);
    chk_t("pre_rst_oreq", bus.out_req, f[0]);
    chk("pre_rst_ovf", 16'(bus.rx_overflow), 16'd1);
    #2 rst = 1'b1;
    #1 chk_idle_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_hrr", 16'(bus.host_req_ready), 16'd1);
    chk("post_rst_orv", 16'(bus.out_req_valid), 16'd0);
    chk("post_rst_hrv", 16'(bus.host_rsp_valid), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
